// File: rtl/sb_trans_scheduler_if.sv
// Request/handshake bundle between the sideband requesters, the scheduler and the
// transaction generator. The master modport is the requester/generator side.
interface sb_trans_scheduler_if;
  logic       lt_req;
  logic       at_rsp_req;
  logic       at_cmd_req;
  logic       at_rsp_rcvd;
  logic       trans_sent;
  logic       disconnected_s;
  logic [2:0] trans_sel;
  logic       busy;
  logic       lt_done;
  logic       at_rsp_done;
  logic       at_cmd_done;
  logic       at_cmd_fail;
  logic       sent_timeout;

  modport master (
    output lt_req, at_rsp_req, at_cmd_req, at_rsp_rcvd, trans_sent, disconnected_s,
    input  trans_sel, busy, lt_done, at_rsp_done, at_cmd_done, at_cmd_fail, sent_timeout
  );

  modport slave (
    input  lt_req, at_rsp_req, at_cmd_req, at_rsp_rcvd, trans_sent, disconnected_s,
    output trans_sel, busy, lt_done, at_rsp_done, at_cmd_done, at_cmd_fail, sent_timeout
  );
endinterface

// File: rtl/sb_trans_scheduler.sv
// Sideband transaction scheduler: latches LT / AT-response / AT-command requests, issues them
// to the generator by fixed priority and tracks the outstanding AT command with retry.
//   state     | meaning
//   IDLE      | waiting for an eligible pending request while connected
//   ISSUE     | trans_sel driven for one cycle
//   WAIT_SENT | waiting for trans_sent, bounded by SENT_TIMEOUT
//   GAP       | enforced idle spacing before the next issue
module sb_trans_scheduler #(
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned SENT_TIMEOUT = 255,
  parameter int unsigned RSP_TIMEOUT  = 1000,
  parameter int unsigned MAX_RETRY    = 2
) (
  input logic               sb_clk_i,
  input logic               rst_ni,
  sb_trans_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_SENT, GAP} state_e;

  localparam logic [2:0]  SEL_NONE    = 3'd0;
  localparam logic [2:0]  SEL_CMD     = 3'd2;
  localparam logic [2:0]  SEL_RSP     = 3'd3;
  localparam logic [2:0]  SEL_LT      = 3'd4;
  localparam logic [7:0]  SENT_TO_L   = 8'(SENT_TIMEOUT);
  localparam logic [15:0] RSP_TO_L    = 16'(RSP_TIMEOUT);
  localparam logic [1:0]  MAX_RETRY_L = 2'(MAX_RETRY);
  // GAP is entered with GAP_CYCLES-1 so that exactly GAP_CYCLES cycles are spent there.
  localparam logic [3:0]  GAP_LOAD    = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_e      state_q;
  logic [2:0]  cur_sel_q, trans_sel_q;
  logic [7:0]  sent_tmr_q;
  logic [3:0]  gap_cnt_q;
  logic [15:0] rsp_tmr_q;
  logic [1:0]  retry_cnt_q;
  logic        pend_lt_q, pend_rsp_q, pend_cmd_q, cmd_out_q;
  logic        pend_lt_d, pend_rsp_d, pend_cmd_d;
  logic        lt_done_q, at_rsp_done_q, at_cmd_done_q, at_cmd_fail_q, sent_timeout_q;
  logic        sent_ok, cmd_sent, cmd_retry;
  logic [2:0]  issue_sel;

  assign sent_ok   = (state_q == WAIT_SENT) & bus.trans_sent & ~bus.disconnected_s;
  assign cmd_sent  = sent_ok & (cur_sel_q == SEL_CMD);
  assign cmd_retry = ~bus.disconnected_s & cmd_out_q & ~bus.at_rsp_rcvd &
                     (rsp_tmr_q == RSP_TO_L) & (retry_cnt_q < MAX_RETRY_L);

  always_comb begin
    issue_sel = SEL_NONE;
    if (pend_lt_q)                    issue_sel = SEL_LT;
    else if (pend_rsp_q)              issue_sel = SEL_RSP;
    else if (pend_cmd_q & ~cmd_out_q) issue_sel = SEL_CMD;
  end

  // A new request in the same cycle as its own trans_sent keeps the flag set.
  always_comb begin
    pend_lt_d  = (pend_lt_q  & ~(sent_ok & (cur_sel_q == SEL_LT)))  | bus.lt_req;
    pend_rsp_d = (pend_rsp_q & ~(sent_ok & (cur_sel_q == SEL_RSP))) | bus.at_rsp_req;
    pend_cmd_d = (pend_cmd_q & ~cmd_sent) | bus.at_cmd_req | cmd_retry;
  end

  always_ff @(posedge sb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      cur_sel_q      <= SEL_NONE;
      trans_sel_q    <= SEL_NONE;
      sent_tmr_q     <= '0;
      gap_cnt_q      <= '0;
      lt_done_q      <= 1'b0;
      at_rsp_done_q  <= 1'b0;
      sent_timeout_q <= 1'b0;
    end else begin
      trans_sel_q   <= SEL_NONE;
      lt_done_q     <= 1'b0;
      at_rsp_done_q <= 1'b0;
      if (bus.disconnected_s) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (issue_sel != SEL_NONE) begin
              state_q     <= ISSUE;
              cur_sel_q   <= issue_sel;
              trans_sel_q <= issue_sel;
            end
          end
          ISSUE: begin
            sent_tmr_q <= '0;
            state_q    <= WAIT_SENT;
          end
          WAIT_SENT: begin
            if (bus.trans_sent) begin
              lt_done_q      <= (cur_sel_q == SEL_LT);
              at_rsp_done_q  <= (cur_sel_q == SEL_RSP);
              sent_timeout_q <= 1'b0;
              gap_cnt_q      <= GAP_LOAD;
              state_q        <= GAP;
            end else if (sent_tmr_q == SENT_TO_L) begin
              sent_timeout_q <= 1'b1;
              gap_cnt_q      <= GAP_LOAD;
              state_q        <= GAP;
            end else begin
              sent_tmr_q <= sent_tmr_q + 8'd1;
            end
          end
          GAP: begin
            if (gap_cnt_q == '0) state_q   <= IDLE;
            else                 gap_cnt_q <= gap_cnt_q - 4'd1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Command tracking runs beside the FSM so LT/response traffic continues while a command waits.
  always_ff @(posedge sb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_lt_q     <= 1'b0;
      pend_rsp_q    <= 1'b0;
      pend_cmd_q    <= 1'b0;
      cmd_out_q     <= 1'b0;
      retry_cnt_q   <= '0;
      rsp_tmr_q     <= '0;
      at_cmd_done_q <= 1'b0;
      at_cmd_fail_q <= 1'b0;
    end else begin
      pend_lt_q     <= pend_lt_d;
      pend_rsp_q    <= pend_rsp_d;
      pend_cmd_q    <= pend_cmd_d;
      at_cmd_done_q <= 1'b0;
      at_cmd_fail_q <= 1'b0;
      if (bus.disconnected_s) begin
        cmd_out_q   <= 1'b0;
        retry_cnt_q <= '0;
      end else if (cmd_sent) begin
        cmd_out_q <= 1'b1;
        rsp_tmr_q <= '0;
      end else if (cmd_out_q) begin
        if (bus.at_rsp_rcvd) begin
          cmd_out_q     <= 1'b0;
          retry_cnt_q   <= '0;
          at_cmd_done_q <= 1'b1;
        end else if (rsp_tmr_q == RSP_TO_L) begin
          cmd_out_q <= 1'b0;
          if (retry_cnt_q < MAX_RETRY_L) begin
            retry_cnt_q <= retry_cnt_q + 2'd1;
          end else begin
            retry_cnt_q   <= '0;
            at_cmd_fail_q <= 1'b1;
          end
        end else begin
          rsp_tmr_q <= rsp_tmr_q + 16'd1;
        end
      end
    end
  end

  assign bus.trans_sel    = bus.disconnected_s ? SEL_NONE : trans_sel_q;
  assign bus.busy         = (state_q != IDLE) | pend_lt_q | pend_rsp_q | pend_cmd_q | cmd_out_q;
  assign bus.lt_done      = lt_done_q;
  assign bus.at_rsp_done  = at_rsp_done_q;
  assign bus.at_cmd_done  = at_cmd_done_q;
  assign bus.at_cmd_fail  = at_cmd_fail_q;
  assign bus.sent_timeout = sent_timeout_q;

endmodule

// File: tb/tb_sb_trans_scheduler.sv
// Bench for sb_trans_scheduler: acts as requester and generator, checks issue order, pulses and
// timeouts against a transaction-level model of pending requests and the outstanding command.
module tb_sb_trans_scheduler;
  localparam int GAP       = 2;
  localparam int SENT_TO   = 255;
  localparam int RSP_TO    = 1000;
  localparam int MAX_RETRY = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sb_trans_scheduler_if io();

  sb_trans_scheduler #(
    .GAP_CYCLES  (GAP),
    .SENT_TIMEOUT(SENT_TO),
    .RSP_TIMEOUT (RSP_TO),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .sb_clk_i(clk),
    .rst_ni  (rst_n),
    .bus     (io)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: what is pending and whether a command awaits its response.
  bit m_pend_lt, m_pend_rsp, m_pend_cmd, m_cmd_out;
  int m_retry = 0;
  int m_rsp_left = -1;
  bit s_lt, s_rsp, s_cmd, s_cmd_out;
  bit e_lt_done, e_rsp_done, e_cmd_done, e_fail;

  // Generator / link partner behaviour.
  int gen_type = 0, gen_cnt = 0;
  bit gen_auto = 1'b1;
  int lat_min = 1, lat_max = 40;
  bit rsp_auto = 1'b1;
  int rsp_min = 5, rsp_max = 300;
  int rsp_cnt = 0;
  bit disc = 1'b0;

  int iter = 0, last_sent = -100, last_issue = 0, n_sent = 0;
  bit prev_nz = 1'b0;
  int n_issue[5];
  int n_cmd_done = 0, n_fail = 0;
  int order_q[$];
  int cmd_iss_q[$];

  task automatic step(input bit lt = 1'b0, input bit rsp = 1'b0, input bit cmd = 1'b0);
    int sel, exp_sel;
    bit sent, rcvd;
    @(posedge clk);
    #1;
    iter++;
    chk("lt_done", int'(io.lt_done), int'(e_lt_done));
    chk("at_rsp_done", int'(io.at_rsp_done), int'(e_rsp_done));
    chk("at_cmd_done", int'(io.at_cmd_done), int'(e_cmd_done));
    chk("at_cmd_fail", int'(io.at_cmd_fail), int'(e_fail));
    if (io.at_cmd_done) n_cmd_done++;
    if (io.at_cmd_fail) n_fail++;
    sel = int'(io.trans_sel);
    if (io.disconnected_s) chk("sel_while_disc", sel, 0);
    if (sel != 0) begin
      exp_sel = s_lt ? 4 : s_rsp ? 3 : (s_cmd && !s_cmd_out) ? 2 : 0;
      chk("issue_sel", sel, exp_sel);
      chk("sel_one_cycle", int'(prev_nz), 0);
      chk("issue_gap", (iter - last_sent > GAP) ? 1 : 0, 1);
      if (sel < 5) n_issue[sel]++;
      if (sel == 2) cmd_iss_q.push_back(iter);
      order_q.push_back(sel);
      last_issue = iter;
      gen_type = sel;
      gen_cnt = int'($urandom_range(lat_max, lat_min)) + 1;
    end
    prev_nz = (sel != 0);
    s_lt = m_pend_lt; s_rsp = m_pend_rsp; s_cmd = m_pend_cmd; s_cmd_out = m_cmd_out;

    sent = 1'b0;
    rcvd = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) rcvd = 1'b1;
    end
    if (gen_type != 0 && gen_auto && !disc) begin
      gen_cnt--;
      if (gen_cnt <= 0) sent = 1'b1;
    end
    io.lt_req = lt; io.at_rsp_req = rsp; io.at_cmd_req = cmd;
    io.trans_sent = sent; io.at_rsp_rcvd = rcvd; io.disconnected_s = disc;

    e_lt_done  = sent && gen_type == 4;
    e_rsp_done = sent && gen_type == 3;
    e_cmd_done = rcvd && m_cmd_out && !disc;
    e_fail     = 1'b0;
    if (m_rsp_left > 0) m_rsp_left--;
    if (disc) begin
      m_cmd_out = 0; m_retry = 0; m_rsp_left = -1; gen_type = 0; rsp_cnt = 0;
    end else if (rcvd && m_cmd_out) begin
      m_cmd_out = 0; m_retry = 0; m_rsp_left = -1;
    end else if (m_cmd_out && m_rsp_left == 0) begin
      m_cmd_out = 0; m_rsp_left = -1;
      if (m_retry < MAX_RETRY) begin
        m_retry++;
        m_pend_cmd = 1'b1;
      end else begin
        e_fail = 1'b1;
        m_retry = 0;
      end
    end
    if (sent) begin
      case (gen_type)
        4: m_pend_lt = 1'b0;
        3: m_pend_rsp = 1'b0;
        2: begin
          m_pend_cmd = 1'b0;
          m_cmd_out = 1'b1;
          m_rsp_left = RSP_TO + 1;
          if (rsp_auto) rsp_cnt = int'($urandom_range(rsp_max, rsp_min));
        end
        default: ;
      endcase
      gen_type = 0;
      last_sent = iter;
      n_sent++;
    end
    m_pend_lt  = m_pend_lt  | lt;
    m_pend_rsp = m_pend_rsp | rsp;
    m_pend_cmd = m_pend_cmd | cmd;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while ((io.busy || gen_type != 0 || rsp_cnt > 0) && n < budget);
    chk({tag, "_idle"}, int'(io.busy), 0);
  endtask

  int r, t, el, k0, n2, d0, f0;
  bit seen, a, b, c;

  initial begin
    io.lt_req = 0; io.at_rsp_req = 0; io.at_cmd_req = 0;
    io.at_rsp_rcvd = 0; io.trans_sent = 0; io.disconnected_s = 0;
    foreach (n_issue[i]) n_issue[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_trans_sel", int'(io.trans_sel), 0);
    chk("rst_busy", int'(io.busy), 0);
    chk("rst_lt_done", int'(io.lt_done), 0);
    chk("rst_at_rsp_done", int'(io.at_rsp_done), 0);
    chk("rst_at_cmd_done", int'(io.at_cmd_done), 0);
    chk("rst_at_cmd_fail", int'(io.at_cmd_fail), 0);
    chk("rst_sent_timeout", int'(io.sent_timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();

    // Single LT with trans_sent 20 cycles after issue.
    lat_min = 20; lat_max = 20;
    step(1'b1, 1'b0, 1'b0);
    r = iter;
    t = n_sent;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      seen = (n_sent != t);
    end
    chk("lt_sent_seen", int'(seen), 1);
    chk("lt_issue_latency", last_issue - r, 2);
    chk("lt_sent_delay", last_sent - last_issue, 20);
    step();
    step();
    chk("lt_gap_busy", int'(io.busy), 1);
    step();
    chk("lt_idle_after_gap", int'(io.busy), 0);

    // Three simultaneous requests: priority order.
    lat_min = 1; lat_max = 40;
    order_q.delete();
    step(1'b1, 1'b1, 1'b1);
    wait_idle("prio", 2000);
    chk("prio_count", order_q.size(), 3);
    if (order_q.size() == 3) begin
      chk("prio_first", order_q[0], 4);
      chk("prio_second", order_q[1], 3);
      chk("prio_third", order_q[2], 2);
    end

    // Randomized traffic with merging and overlap; responses arrive before timeout.
    for (int ep = 0; ep < 25; ep++) begin
      do begin
        a = 1'($urandom_range(1, 0));
        b = 1'($urandom_range(1, 0));
        c = 1'($urandom_range(1, 0));
      end while (!(a | b | c));
      step(a, b, c);
      for (int i = 0; i < 80; i++)
        step($urandom_range(19, 0) == 0, $urandom_range(19, 0) == 0, $urandom_range(29, 0) == 0);
      wait_idle("rand", 3000);
    end

    // Command never answered: two retries then failure.
    rsp_auto = 0; lat_min = 5; lat_max = 5;
    n2 = n_issue[2]; f0 = n_fail;
    cmd_iss_q.delete();
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3400 && n_fail == f0; i++) step();
    chk("retry_fail_pulses", n_fail - f0, 1);
    chk("retry_issue_count", n_issue[2] - n2, 3);
    if (cmd_iss_q.size() == 3) begin
      el = cmd_iss_q[1] - cmd_iss_q[0];
      chk("retry_interval1", (el >= RSP_TO && el <= RSP_TO + 15) ? 1 : 0, 1);
      el = cmd_iss_q[2] - cmd_iss_q[1];
      chk("retry_interval2", (el >= RSP_TO && el <= RSP_TO + 15) ? 1 : 0, 1);
    end
    wait_idle("retry", 100);

    // Response on the exact expiry cycle: counts as answered.
    rsp_auto = 1; rsp_min = RSP_TO + 1; rsp_max = RSP_TO + 1;
    n2 = n_issue[2]; f0 = n_fail; d0 = n_cmd_done;
    step(1'b0, 1'b0, 1'b1);
    wait_idle("coinc", 1300);
    repeat (20) step();
    chk("coinc_done", n_cmd_done - d0, 1);
    chk("coinc_no_reissue", n_issue[2] - n2, 1);
    chk("coinc_no_fail", n_fail - f0, 0);
    rsp_min = 5; rsp_max = 300;

    // Disconnect while waiting for a response transaction to be sent.
    lat_min = 30; lat_max = 30;
    k0 = n_issue[3];
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10 && n_issue[3] == k0; i++) step();
    chk("disc_first_issue", n_issue[3] - k0, 1);
    repeat (5) step();
    disc = 1'b1;
    repeat (20) step();
    chk("disc_no_issue", n_issue[3] - k0, 1);
    chk("disc_busy_pending", int'(io.busy), 1);
    disc = 1'b0;
    wait_idle("disc", 200);
    chk("disc_reissue", n_issue[3] - k0, 2);

    // Generator never answers: sent timeout, re-issue, cleared on success.
    gen_auto = 0; lat_min = 10; lat_max = 10;
    k0 = n_issue[4];
    step(1'b1, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step();
      seen = io.sent_timeout;
    end
    chk("sto_seen", int'(seen), 1);
    el = iter - last_issue;
    chk("sto_timing", (el >= SENT_TO && el <= SENT_TO + 4) ? 1 : 0, 1);
    gen_auto = 1;
    for (int i = 0; i < 20 && n_issue[4] - k0 < 2; i++) step();
    chk("sto_reissue", n_issue[4] - k0, 2);
    chk("sto_sticky", int'(io.sent_timeout), 1);
    wait_idle("sto", 100);
    chk("sto_cleared", int'(io.sent_timeout), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
